// File: rtl/pool_layer_mm_if.sv
// ---------------------------------------------------------------------------
// pool_layer_mm_if
// Purpose : groups the frame-write, control and result handshake signals of
//           pool_layer_mm into one bundle. clk/rst stay plain module ports.
// Signals :
//   i_ibuf_we      [input_channels]                       per-channel write strobe
//   i_ibuf_wr_data [input_channels][datatype_size]        per-channel write data
//   i_start                                               start pooling buffered frame
//   i_mode                                                0=max, 1=avg (sampled with i_start)
//   i_next_busy                                           downstream cannot accept
//   o_busy                                                scan in progress
//   o_valid                                               o_func_data is valid
//   o_func_data    [input_channels][output_datatype_size] pooled result per channel
//   o_done                                                one-cycle end-of-frame pulse
// Modports: slave = pooling layer, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface pool_layer_mm_if #(
  parameter int input_channels       = 6,
  parameter int datatype_size        = 2,
  parameter int output_datatype_size = 2
);
  logic [input_channels-1:0]                           i_ibuf_we;
  logic [input_channels-1:0][datatype_size-1:0]        i_ibuf_wr_data;
  logic                                                i_start;
  logic                                                i_mode;
  logic                                                i_next_busy;
  logic                                                o_busy;
  logic                                                o_valid;
  logic [input_channels-1:0][output_datatype_size-1:0] o_func_data;
  logic                                                o_done;

  modport slave (
    input  i_ibuf_we, i_ibuf_wr_data, i_start, i_mode, i_next_busy,
    output o_busy, o_valid, o_func_data, o_done
  );

  modport master (
    output i_ibuf_we, i_ibuf_wr_data, i_start, i_mode, i_next_busy,
    input  o_busy, o_valid, o_func_data, o_done
  );
endinterface

// File: rtl/pool_layer_mm.sv
// ---------------------------------------------------------------------------
// pool_layer_mm
// Purpose : multi-channel max/avg pooling layer. Each channel buffers one
//           img_width x img_width frame (raster order), then kernel_dim x
//           kernel_dim windows are scanned at the given stride, one window
//           element per cycle for all channels in parallel. One pooled value
//           per channel is emitted per window, in raster window order, with
//           backpressure from the next layer.
// Ports   :
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - pool_layer_mm_if.slave (write path, start/mode, result handshake)
// Config  : define POOL_RELU_EN to clamp negative results to 0 (fused ReLU)
//           when a result is registered; undefined passes signed results.
// ---------------------------------------------------------------------------
module pool_layer_mm #(
  parameter int input_channels       = 6,
  parameter int img_width            = 24,
  parameter int kernel_dim           = 2,
  parameter int stride               = 2,
  parameter int datatype_size        = 2,
  parameter int output_datatype_size = 2
) (
  input  logic            clk,
  input  logic            rst,
  pool_layer_mm_if.slave  bus
);

  localparam int K2    = kernel_dim * kernel_dim;
  localparam int OW    = (img_width - kernel_dim) / stride + 1;
  localparam int DEPTH = img_width * img_width;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(img_width + 1);
  localparam int SH    = $clog2(K2);
  localparam int ACCW  = datatype_size + SH;
  localparam int ODW   = output_datatype_size;

  localparam logic [CW-1:0] LASTPOS = CW'((OW - 1) * stride);
  localparam logic [CW-1:0] KLAST   = CW'(kernel_dim - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t                                 r_state;
  logic [datatype_size-1:0]               r_buf [input_channels][DEPTH];
  logic [AW-1:0]                          r_wp  [input_channels];
  logic signed [ACCW-1:0]                 r_acc [input_channels];
  logic                                   r_mode;
  logic [CW-1:0]                          r_row;
  logic [CW-1:0]                          r_col;
  logic [CW-1:0]                          r_kr;
  logic [CW-1:0]                          r_kc;
  logic                                   r_busy;
  logic                                   r_valid;
  logic                                   r_done;
  logic [input_channels-1:0][ODW-1:0]     r_func_data;

  logic [AW-1:0]                          w_addr;
  logic                                   w_first;
  logic                                   w_last_elem;
  logic                                   w_last_win;
  logic                                   w_accept;
  logic                                   w_finish;
  logic signed [ACCW-1:0]                 w_elem [input_channels];
  logic signed [ACCW-1:0]                 w_next [input_channels];
  logic [datatype_size-1:0]               w_pool [input_channels];
  logic [input_channels-1:0][ODW-1:0]     w_out;

  // Window element address, accumulator update and final result shaping.
  // Max and avg results both fit in datatype_size signed bits, so the
  // result is trimmed to that width before sign-extending to the output.
  always_comb begin
    w_addr      = AW'((r_row + r_kr) * img_width + r_col + r_kc);
    w_first     = (r_kr == '0) && (r_kc == '0);
    w_last_elem = (r_kr == KLAST) && (r_kc == KLAST);
    w_last_win  = (r_row == LASTPOS) && (r_col == LASTPOS);
    w_accept    = (r_state == EMIT) && r_valid && !bus.i_next_busy;
    w_finish    = w_accept && w_last_win;
    w_out       = '0;
    for (int c = 0; c < input_channels; c++) begin
      w_elem[c] = ACCW'($signed(r_buf[c][w_addr]));
      if (w_first)
        w_next[c] = w_elem[c];
      else if (r_mode)
        w_next[c] = r_acc[c] + w_elem[c];
      else
        w_next[c] = (w_elem[c] > r_acc[c]) ? w_elem[c] : r_acc[c];
      w_pool[c] = datatype_size'(r_mode ? (w_next[c] >>> SH) : w_next[c]);
`ifdef POOL_RELU_EN
      w_out[c]  = w_pool[c][datatype_size-1] ? '0 : ODW'($signed(w_pool[c]));
`else
      w_out[c]  = ODW'($signed(w_pool[c]));
`endif
    end
  end

  // Frame storage is plain memory without reset so it can map onto RAM;
  // stale contents are always overwritten by the next frame before use.
  always_ff @(posedge clk) begin
    for (int c = 0; c < input_channels; c++) begin
      if (bus.i_ibuf_we[c] && !r_busy)
        r_buf[c][r_wp[c]] <= bus.i_ibuf_wr_data[c];
    end
  end

  // Write pointers freeze during a scan and rewind once the frame is done.
  always_ff @(posedge clk) begin
    for (int c = 0; c < input_channels; c++) begin
      if (rst || w_finish)
        r_wp[c] <= '0;
      else if (bus.i_ibuf_we[c] && !r_busy)
        r_wp[c] <= (r_wp[c] == AW'(DEPTH - 1)) ? '0 : r_wp[c] + AW'(1);
    end
  end

  // Scan FSM: ACCUM walks the K2 window elements, EMIT holds the result
  // until the next layer takes it, then steps to the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mode      <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_func_data <= '0;
      for (int c = 0; c < input_channels; c++) r_acc[c] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_mode  <= bus.i_mode;
            r_row   <= '0;
            r_col   <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
            r_busy  <= 1'b1;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          for (int c = 0; c < input_channels; c++) r_acc[c] <= w_next[c];
          if (w_last_elem) begin
            r_func_data <= w_out;
            r_valid     <= 1'b1;
            r_kr        <= '0;
            r_kc        <= '0;
            r_state     <= EMIT;
          end else if (r_kc == KLAST) begin
            r_kc <= '0;
            r_kr <= r_kr + CW'(1);
          end else begin
            r_kc <= r_kc + CW'(1);
          end
        end
        EMIT: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            if (w_last_win) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              if (r_col == LASTPOS) begin
                r_col <= '0;
                r_row <= r_row + CW'(stride);
              end else begin
                r_col <= r_col + CW'(stride);
              end
              r_state <= ACCUM;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_valid     = r_valid;
  assign bus.o_done      = r_done;
  assign bus.o_func_data = r_func_data;

endmodule

// File: tb/tb_pool_layer_mm.sv
// ---------------------------------------------------------------------------
// tb_pool_layer_mm
// Two pooling instances: A (2 channels, 4x4 frame, k2 s2, 8-bit in, 10-bit
// out) and B (1 channel, 3x3 frame, k2 s1, 8-bit). A is driven from a table
// of whole-frame vectors; B and the reset scenario are hand-written.
// ---------------------------------------------------------------------------
module tb_pool_layer_mm;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pool_layer_mm_if #(.input_channels(2), .datatype_size(8), .output_datatype_size(10)) ifA ();
  pool_layer_mm_if #(.input_channels(1), .datatype_size(8), .output_datatype_size(8))  ifB ();

  pool_layer_mm #(
    .input_channels(2), .img_width(4), .kernel_dim(2), .stride(2),
    .datatype_size(8), .output_datatype_size(10)
  ) dutA (.clk(clk), .rst(rst), .bus(ifA));

  pool_layer_mm #(
    .input_channels(1), .img_width(3), .kernel_dim(2), .stride(1),
    .datatype_size(8), .output_datatype_size(8)
  ) dutB (.clk(clk), .rst(rst), .bus(ifB));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string name;
    bit    mode;
    int    frameSel;
    int    stallIdx;
    int    stallCycles;
    int    exp0 [4];
    int    exp1 [4];
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int relu(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Frame 0: ch0 = 0..15, ch1 = -(0..15); frame 1: ch0 = 0..15, ch1 all -3.
  function automatic int frameVal(input int sel, input int ch, input int idx);
    if (ch == 0) return idx;
    return (sel == 0) ? -idx : -3;
  endfunction

  // Writes a frame into instance A, runs one scan and checks all outputs.
  task automatic applyStimulus(input int i);
    int cnt;
    for (int idx = 0; idx < 16; idx++) begin
      ifA.i_ibuf_we         = 2'b11;
      ifA.i_ibuf_wr_data[0] = 8'(frameVal(vecs[i].frameSel, 0, idx));
      ifA.i_ibuf_wr_data[1] = 8'(frameVal(vecs[i].frameSel, 1, idx));
      @(negedge clk);
    end
    ifA.i_ibuf_we = '0;
    ifA.i_mode    = vecs[i].mode;
    ifA.i_start   = 1'b1;
    @(negedge clk);
    ifA.i_start = 1'b0;
    ifA.i_mode  = ~vecs[i].mode;
    checkOutput($sformatf("%s.busy_after_start", vecs[i].name), int'(ifA.o_busy), 1);
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      while (!ifA.o_valid && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      checkOutput($sformatf("%s.latency%0d", vecs[i].name, k), cnt, 4);
      checkOutput($sformatf("%s.ch0_out%0d", vecs[i].name, k),
                  int'($signed(ifA.o_func_data[0])), vecs[i].exp0[k]);
      checkOutput($sformatf("%s.ch1_out%0d", vecs[i].name, k),
                  int'($signed(ifA.o_func_data[1])), relu(vecs[i].exp1[k]));
      if (k == vecs[i].stallIdx) begin
        ifA.i_next_busy = 1'b1;
        for (int s = 0; s < vecs[i].stallCycles; s++) begin
          @(negedge clk);
          checkOutput($sformatf("%s.held_valid%0d", vecs[i].name, s), int'(ifA.o_valid), 1);
          checkOutput($sformatf("%s.held_data%0d", vecs[i].name, s),
                      int'($signed(ifA.o_func_data[0])), vecs[i].exp0[k]);
        end
        ifA.i_next_busy = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("%s.valid_drop%0d", vecs[i].name, k), int'(ifA.o_valid), 0);
      if (k == 3) begin
        checkOutput($sformatf("%s.done", vecs[i].name), int'(ifA.o_done), 1);
        checkOutput($sformatf("%s.busy_end", vecs[i].name), int'(ifA.o_busy), 0);
        @(negedge clk);
        checkOutput($sformatf("%s.done_pulse", vecs[i].name), int'(ifA.o_done), 0);
      end else begin
        checkOutput($sformatf("%s.no_early_done%0d", vecs[i].name, k), int'(ifA.o_done), 0);
      end
    end
  endtask

  // Frame 1..9 into instance B, one scan; optionally pokes i_start and
  // writes into the scan to prove both are ignored while busy.
  task automatic runB(input string name, input bit mode, input int e0, input int e1,
                      input int e2, input int e3, input bit interfere);
    int exp [4];
    int cnt;
    int extra;
    exp = '{e0, e1, e2, e3};
    for (int idx = 0; idx < 9; idx++) begin
      ifB.i_ibuf_we         = 1'b1;
      ifB.i_ibuf_wr_data[0] = 8'(idx + 1);
      @(negedge clk);
    end
    ifB.i_ibuf_we = '0;
    ifB.i_mode    = mode;
    ifB.i_start   = 1'b1;
    @(negedge clk);
    ifB.i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      while (!ifB.o_valid && cnt < 40) begin
        if (interfere && k == 1 && cnt < 3) begin
          ifB.i_start           = 1'b1;
          ifB.i_ibuf_we         = 1'b1;
          ifB.i_ibuf_wr_data[0] = 8'd100;
        end
        @(negedge clk);
        ifB.i_start   = 1'b0;
        ifB.i_ibuf_we = '0;
        cnt++;
      end
      checkOutput($sformatf("%s.latency%0d", name, k), cnt, 4);
      checkOutput($sformatf("%s.out%0d", name, k), int'($signed(ifB.o_func_data[0])), exp[k]);
      @(negedge clk);
    end
    checkOutput($sformatf("%s.done", name), int'(ifB.o_done), 1);
    extra = 0;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      if (ifB.o_valid || ifB.o_busy) extra++;
    end
    checkOutput($sformatf("%s.no_extra_output", name), extra, 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int quiet;

    vecs[0].name = "A_max";   vecs[0].mode = 1'b0; vecs[0].frameSel = 0;
    vecs[0].stallIdx = -1;    vecs[0].stallCycles = 0;
    vecs[0].exp0 = '{5, 7, 13, 15};  vecs[0].exp1 = '{0, -2, -8, -10};
    vecs[1].name = "A_avg";   vecs[1].mode = 1'b1; vecs[1].frameSel = 0;
    vecs[1].stallIdx = -1;    vecs[1].stallCycles = 0;
    vecs[1].exp0 = '{2, 4, 10, 12};  vecs[1].exp1 = '{-3, -5, -11, -13};
    vecs[2].name = "A_stall"; vecs[2].mode = 1'b0; vecs[2].frameSel = 0;
    vecs[2].stallIdx = 1;     vecs[2].stallCycles = 5;
    vecs[2].exp0 = '{5, 7, 13, 15};  vecs[2].exp1 = '{0, -2, -8, -10};
    vecs[3].name = "A_neg3max"; vecs[3].mode = 1'b0; vecs[3].frameSel = 1;
    vecs[3].stallIdx = -1;    vecs[3].stallCycles = 0;
    vecs[3].exp0 = '{5, 7, 13, 15};  vecs[3].exp1 = '{-3, -3, -3, -3};
    vecs[4].name = "A_neg3avg"; vecs[4].mode = 1'b1; vecs[4].frameSel = 1;
    vecs[4].stallIdx = 3;     vecs[4].stallCycles = 2;
    vecs[4].exp0 = '{2, 4, 10, 12};  vecs[4].exp1 = '{-3, -3, -3, -3};

    rst = 1'b1;
    ifA.i_ibuf_we = '0; ifA.i_ibuf_wr_data = '0; ifA.i_start = 1'b0;
    ifA.i_mode = 1'b0;  ifA.i_next_busy = 1'b0;
    ifB.i_ibuf_we = '0; ifB.i_ibuf_wr_data = '0; ifB.i_start = 1'b0;
    ifB.i_mode = 1'b0;  ifB.i_next_busy = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy",  int'(ifA.o_busy), 0);
    checkOutput("reset.valid", int'(ifA.o_valid), 0);
    checkOutput("reset.done",  int'(ifA.o_done), 0);
    checkOutput("reset.data",  int'(ifA.o_func_data), 0);
    checkOutput("reset.B_busy", int'(ifB.o_busy), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) applyStimulus(i);

    // Reset during the second window's accumulation, then a clean frame.
    for (int idx = 0; idx < 16; idx++) begin
      ifA.i_ibuf_we         = 2'b11;
      ifA.i_ibuf_wr_data[0] = 8'(idx + 50);
      ifA.i_ibuf_wr_data[1] = 8'(idx + 50);
      @(negedge clk);
    end
    ifA.i_ibuf_we = '0;
    ifA.i_mode    = 1'b0;
    ifA.i_start   = 1'b1;
    @(negedge clk);
    ifA.i_start = 1'b0;
    quiet = 0;
    while (!ifA.o_valid && quiet < 40) begin
      @(negedge clk);
      quiet++;
    end
    checkOutput("rstmid.first_out", int'($signed(ifA.o_func_data[0])), 55);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstmid.busy",  int'(ifA.o_busy), 0);
    checkOutput("rstmid.valid", int'(ifA.o_valid), 0);
    checkOutput("rstmid.done",  int'(ifA.o_done), 0);
    checkOutput("rstmid.data",  int'(ifA.o_func_data), 0);
    quiet = 0;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      if (ifA.o_valid || ifA.o_done || ifA.o_busy) quiet++;
    end
    checkOutput("rstmid.stays_idle", quiet, 0);
    applyStimulus(0);

    runB("B_max_interfere", 1'b0, 5, 6, 8, 9, 1'b1);
    runB("B_avg", 1'b1, 3, 4, 6, 7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
